// File: rtl/max6675_spi_ctrl_if.sv
// Signal bundle between the MAX6675 reader and its host: request controls,
// the three SPI pins and the registered result bus.
interface max6675_spi_ctrl_if;
    logic        start;
    logic        auto_en;
    logic        spi_so;
    logic        spi_cs_n;
    logic        spi_sck;
    logic [15:0] temp_data;
    logic [11:0] temp_q;
    logic        temp_valid;
    logic        open_tc;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic        busy;

    modport master (
        input  start, auto_en, spi_so,
        output spi_cs_n, spi_sck, temp_data, temp_q, temp_valid,
               open_tc, frame_err, frame_cnt, busy
    );

    modport slave (
        output start, auto_en, spi_so,
        input  spi_cs_n, spi_sck, temp_data, temp_q, temp_valid,
               open_tc, frame_err, frame_cnt, busy
    );
endinterface

// File: rtl/max6675_spi_ctrl.sv
// MAX6675 read sequencer: enforces the conversion interval, clocks out one
// 16-bit frame, validates it and holds the last good reading.
module max6675_spi_ctrl #(
    parameter int unsigned CLK_DIV     = 8,
    parameter int unsigned CONV_CYCLES = 11_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    max6675_spi_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_SHIFT_H = 3'd3,
        S_SHIFT_L = 3'd4
    } state_t;

    localparam int                 DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [31:0]        CONV_LAST = 32'(CONV_CYCLES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [DIV_W-1:0]   r_div;
    logic [31:0]        r_conv;
    logic [3:0]         r_bit;
    logic [15:0]        r_shreg;
    logic               r_so_meta;
    logic               r_so_sync;
    logic               r_pending;
    logic               r_cs_n;
    logic               r_sck;
    logic               r_busy;
    logic               r_temp_valid;
    logic [15:0]        r_temp_data;
    logic [11:0]        r_temp_q;
    logic               r_open_tc;
    logic               r_frame_err;
    logic [15:0]        r_frame_cnt;

    logic               w_div_done;
    logic               w_conv_done;
    logic               w_take;
    logic               w_frame_done;
    logic               w_bad;
    logic               w_next_active;

    assign w_div_done  = (r_div == DIV_LAST);
    assign w_conv_done = (r_conv == CONV_LAST);
    assign w_take      = (r_state == S_IDLE) && (bus.auto_en || r_pending || bus.start);
    assign w_bad       = r_shreg[15] | r_shreg[1];

    // Next-state decode and frame-completion strobe
    always_comb begin
        w_next        = r_state;
        w_frame_done  = 1'b0;
        w_next_active = 1'b0;
        case (r_state)
            S_WAIT: begin
                if (w_conv_done) w_next = S_IDLE;
                else             w_next = S_WAIT;
            end
            S_IDLE: begin
                if (w_take) w_next = S_SETUP;
                else        w_next = S_IDLE;
            end
            S_SETUP: begin
                if (w_div_done) w_next = S_SHIFT_H;
                else            w_next = S_SETUP;
            end
            S_SHIFT_H: begin
                if (w_div_done) w_next = S_SHIFT_L;
                else            w_next = S_SHIFT_H;
            end
            S_SHIFT_L: begin
                if (w_div_done && (r_bit == 4'd0)) begin
                    w_next       = S_WAIT;
                    w_frame_done = 1'b1;
                end else if (w_div_done) begin
                    w_next = S_SHIFT_H;
                end else begin
                    w_next = S_SHIFT_L;
                end
            end
            default: w_next = S_WAIT;
        endcase
        if ((w_next == S_SETUP) || (w_next == S_SHIFT_H) || (w_next == S_SHIFT_L)) begin
            w_next_active = 1'b1;
        end else begin
            w_next_active = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_WAIT;
        else          r_state <= w_next;
    end

    // Timing counters, SO synchronizer, shifter and request latch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div     <= '0;
            r_conv    <= 32'd0;
            r_bit     <= 4'd15;
            r_shreg   <= 16'd0;
            r_so_meta <= 1'b0;
            r_so_sync <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_so_meta <= bus.spi_so;
            r_so_sync <= r_so_meta;
            // Divider restarts on every phase change so each phase is CLK_DIV long
            if ((w_next != r_state) || !w_next_active) r_div <= '0;
            else                                       r_div <= r_div + DIV_ONE;
            if ((r_state == S_WAIT) && !w_conv_done) r_conv <= r_conv + 32'd1;
            else                                     r_conv <= 32'd0;
            if (r_state == S_SETUP)
                r_bit <= 4'd15;
            else if ((r_state == S_SHIFT_L) && w_div_done && (r_bit != 4'd0))
                r_bit <= r_bit - 4'd1;
            if ((r_state == S_SHIFT_H) && w_div_done)
                r_shreg <= {r_shreg[14:0], r_so_sync};
            // A start coinciding with auto mode is remembered but absorbed by the next SETUP
            if (w_take)          r_pending <= bus.start & bus.auto_en;
            else if (bus.start)  r_pending <= 1'b1;
        end
    end

    // Registered pins and result bus, decoded from the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cs_n       <= 1'b1;
            r_sck        <= 1'b0;
            r_busy       <= 1'b1;
            r_temp_valid <= 1'b0;
            r_temp_data  <= 16'd0;
            r_temp_q     <= 12'd0;
            r_open_tc    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_cs_n       <= !w_next_active;
            r_sck        <= (w_next == S_SHIFT_H);
            r_busy       <= (w_next != S_IDLE);
            r_temp_valid <= w_frame_done;
            if (w_frame_done) begin
                r_frame_err <= w_bad;
                r_open_tc   <= r_shreg[2];
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (!w_bad) begin
                    r_temp_data <= r_shreg;
                    r_temp_q    <= r_shreg[14:3];
                end
            end
        end
    end

    assign bus.spi_cs_n   = r_cs_n;
    assign bus.spi_sck    = r_sck;
    assign bus.busy       = r_busy;
    assign bus.temp_valid = r_temp_valid;
    assign bus.temp_data  = r_temp_data;
    assign bus.temp_q     = r_temp_q;
    assign bus.open_tc    = r_open_tc;
    assign bus.frame_err  = r_frame_err;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_max6675_spi_ctrl.sv
// Directed bench for max6675_spi_ctrl with a MAX6675 behavioural sensor
// (CLK_DIV=4, CONV_CYCLES=100).
module tb_max6675_spi_ctrl;
    logic clk;
    logic reset_n;
    max6675_spi_ctrl_if bus();

    max6675_spi_ctrl #(.CLK_DIV(4), .CONV_CYCLES(100)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          n_cmp       = 0;
    int          n_err       = 0;
    int          n_valid     = 0;
    logic [15:0] sensor_word = 16'h0C80;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sensor: presents D15 on CS fall, next bit after each SCK fall
    initial begin
        int idx;
        bus.spi_so = 1'b0;
        forever begin
            @(negedge bus.spi_cs_n);
            idx = 15;
            bus.spi_so = sensor_word[idx];
            while (bus.spi_cs_n === 1'b0) begin
                @(negedge bus.spi_sck or posedge bus.spi_cs_n);
                if ((bus.spi_cs_n === 1'b0) && (idx > 0)) begin
                    idx = idx - 1;
                    bus.spi_so = sensor_word[idx];
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.temp_valid === 1'b1) n_valid++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts cs_n-high samples (h) then cs_n-low samples (l); returns on the first high sample
    task automatic do_frame(output int h, output int l, output int v_fall);
        h = 0;
        l = 0;
        while ((bus.spi_cs_n === 1'b1) && (h < 1000)) begin
            h++;
            @(negedge clk);
        end
        v_fall = n_valid;
        while ((bus.spi_cs_n === 1'b0) && (l < 1000)) begin
            l++;
            @(negedge clk);
        end
        check("frame_timeout", 32'((h >= 1000) || (l >= 1000)), 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] data, input logic [11:0] q,
                                input logic otc, input logic err, input logic [15:0] cnt,
                                input int v_fall);
        check({tag, "_valid"},  32'(bus.temp_valid), 32'd1);
        check({tag, "_pulses"}, 32'(n_valid - v_fall), 32'd1);
        check({tag, "_data"},   32'(bus.temp_data), 32'(data));
        check({tag, "_q"},      32'(bus.temp_q), 32'(q));
        check({tag, "_open"},   32'(bus.open_tc), 32'(otc));
        check({tag, "_err"},    32'(bus.frame_err), 32'(err));
        check({tag, "_cnt"},    32'(bus.frame_cnt), 32'(cnt));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cs_n"},  32'(bus.spi_cs_n), 32'd1);
        check({tag, "_sck"},   32'(bus.spi_sck), 32'd0);
        check({tag, "_data"},  32'(bus.temp_data), 32'd0);
        check({tag, "_q"},     32'(bus.temp_q), 32'd0);
        check({tag, "_valid"}, 32'(bus.temp_valid), 32'd0);
        check({tag, "_open"},  32'(bus.open_tc), 32'd0);
        check({tag, "_err"},   32'(bus.frame_err), 32'd0);
        check({tag, "_cnt"},   32'(bus.frame_cnt), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd1);
    endtask

    initial begin
        int h;
        int l;
        int v;
        int l_first;
        int v_ref;
        int n;
        reset_n     = 1'b0;
        bus.start   = 1'b0;
        bus.auto_en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // Auto mode: boot wait, frame length, period, good / open / absent frames
        reset_n = 1'b1;
        do_frame(h, l, v);
        check("boot_cs_high", 32'(h), 32'd101);
        check("cs_low_len", 32'(l), 32'd132);
        check_result("good", 16'h0C80, 12'h190, 1'b0, 1'b0, 16'd1, v);
        l_first     = l;
        sensor_word = 16'h0C84;
        do_frame(h, l, v);
        check("auto_period", 32'(l_first + h), 32'd233);
        check_result("open_tc", 16'h0C84, 12'h190, 1'b1, 1'b0, 16'd2, v);
        sensor_word = 16'h0C80;
        do_frame(h, l, v);
        check_result("good2", 16'h0C80, 12'h190, 1'b0, 1'b0, 16'd3, v);
        sensor_word = 16'hFFFF;
        do_frame(h, l, v);
        check_result("absent", 16'h0C80, 12'h190, 1'b1, 1'b1, 16'd4, v);

        // Triggered mode: single start from IDLE
        bus.auto_en = 1'b0;
        sensor_word = 16'h0C80;
        @(negedge clk);
        check("valid_one_cycle", 32'(bus.temp_valid), 32'd0);
        n = 1;
        while ((bus.busy === 1'b1) && (n < 300)) begin
            n++;
            @(negedge clk);
        end
        check("wait_len", 32'(n), 32'd100);
        repeat (5) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_cs_n", 32'(bus.spi_cs_n), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_latency", 32'(bus.spi_cs_n), 32'd0);
        do_frame(h, l, v);
        check("trig_cs_low", 32'(l), 32'd132);
        check_result("trig", 16'h0C80, 12'h190, 1'b0, 1'b0, 16'd5, v);
        n = 0;
        repeat (250) begin
            if (bus.spi_cs_n === 1'b0) n++;
            @(negedge clk);
        end
        check("trig_single_frame", 32'(n), 32'd0);
        check("trig_idle_busy", 32'(bus.busy), 32'd0);

        // Two starts during a frame yield exactly one extra frame
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        do_frame(h, l, v);
        check("pend_rest_low", 32'(l), 32'd100);
        check("pend_cnt_a", 32'(bus.frame_cnt), 32'd6);
        do_frame(h, l, v);
        check("pend_gap", 32'(h), 32'd101);
        check_result("pend", 16'h0C80, 12'h190, 1'b0, 1'b0, 16'd7, v);
        n = 0;
        repeat (300) begin
            if (bus.spi_cs_n === 1'b0) n++;
            @(negedge clk);
        end
        check("pend_no_third", 32'(n), 32'd0);

        // One-cycle reset during bit 7 of a frame
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (69) @(negedge clk);
        v_ref   = n_valid;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
        bus.auto_en = 1'b1;
        check_reset_state("midrst");
        do_frame(h, l, v);
        check("midrst_wait", 32'(h), 32'd101);
        check("midrst_no_valid", 32'(v - v_ref), 32'd0);
        check_result("midrst_next", 16'h0C80, 12'h190, 1'b0, 1'b0, 16'd1, v);

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        do_frame(h, l, v);
        check("wrap_cnt", 32'(bus.frame_cnt), 32'd0);
        check("wrap_valid", 32'(bus.temp_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
